// File: rtl/compare_pkg.sv
// Shared encodings for the one-hot magnitude-compare interface and the
// search engine state machine.
package compare_pkg;

  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/compare_search_if.sv
// Probe/result handshake between the search engine (master) and an external
// magnitude comparator (slave) wired as A = probe, B = target.
interface compare_search_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] probe;
  logic             probe_valid;
  logic [2:0]       cmp_res;
  logic             cmp_valid;

  modport master (
    output probe,
    output probe_valid,
    input  cmp_res,
    input  cmp_valid
  );

  modport slave (
    input  probe,
    input  probe_valid,
    output cmp_res,
    output cmp_valid
  );

endinterface

// File: rtl/compare_search_mid.sv
// Floor midpoint of an unsigned [lo, hi] interval, computed one bit wider so
// the difference never wraps before the shift.
module search_mid #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] mid
);

  logic [WIDTH:0] span;

  assign span = {1'b0, hi} - {1'b0, lo};
  assign mid  = WIDTH'({1'b0, lo} + (span >> 1));

endmodule

// File: rtl/compare_search.sv
// Successive-approximation search engine: issues probes to an external
// comparator and binary-searches the unsigned range until equality.
module compare_search
  import compare_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  compare_search_if.master    bus,
  output logic [WIDTH-1:0]    found,
  output logic [STEP_W-1:0]   steps,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [WIDTH-1:0]  ALL_ONES = {WIDTH{1'b1}};
  localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] probe;
  logic             probe_valid;

  logic [WIDTH-1:0] nar_lo;
  logic [WIDTH-1:0] nar_hi;
  logic             nar_err;
  logic             restart;
  logic [WIDTH-1:0] mid_lo;
  logic [WIDTH-1:0] mid_hi;
  logic [WIDTH-1:0] mid;

  assign bus.probe       = probe;
  assign bus.probe_valid = probe_valid;

  // Narrowed interval for the current result; only meaningful in PROBE with
  // cmp_valid high. Bound violations and illegal codes all collapse to nar_err.
  always_comb begin
    nar_lo  = lo;
    nar_hi  = hi;
    nar_err = 1'b0;
    case (bus.cmp_res)
      CMP_GT: begin
        if (probe == '0) nar_err = 1'b1;
        else             nar_hi  = probe - WIDTH'(1);
      end
      CMP_LT: begin
        if (probe == ALL_ONES) nar_err = 1'b1;
        else                   nar_lo  = probe + WIDTH'(1);
      end
      CMP_EQ:  nar_err = 1'b0;
      default: nar_err = 1'b1;
    endcase
    if (!nar_err && (nar_lo > nar_hi)) nar_err = 1'b1;
  end

  // A restart probes the full range; otherwise the midpoint tracks the
  // narrowed interval so the next probe is ready one cycle after a result.
  assign restart = start && (state != PROBE);
  assign mid_lo  = restart ? '0       : nar_lo;
  assign mid_hi  = restart ? ALL_ONES : nar_hi;

  search_mid #(.WIDTH(WIDTH)) u_mid (
    .lo  (mid_lo),
    .hi  (mid_hi),
    .mid (mid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lo          <= '0;
      hi          <= ALL_ONES;
      probe       <= '0;
      probe_valid <= 1'b0;
      found       <= '0;
      steps       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state       <= PROBE;
            lo          <= '0;
            hi          <= ALL_ONES;
            probe       <= mid;
            probe_valid <= 1'b1;
            busy        <= 1'b1;
            steps       <= STEP_W'(1);
            done        <= 1'b0;
            err         <= 1'b0;
          end
        end
        PROBE: begin
          if (bus.cmp_valid) begin
            if (bus.cmp_res == CMP_EQ) begin
              state       <= DONE;
              found       <= probe;
              done        <= 1'b1;
              busy        <= 1'b0;
              probe_valid <= 1'b0;
            end else if (nar_err) begin
              state       <= ERR;
              err         <= 1'b1;
              busy        <= 1'b0;
              probe_valid <= 1'b0;
            end else begin
              lo    <= nar_lo;
              hi    <= nar_hi;
              probe <= mid;
              if (steps != STEP_MAX) steps <= steps + STEP_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_search.sv
// Directed bench for compare_search with a behavioural comparator that can
// inject an illegal code or behave inconsistently.
module tb_compare_search;
  import compare_pkg::*;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  found;
  logic [STEP_W-1:0] steps;
  logic              busy;
  logic              done;
  logic              err;

  compare_search_if #(.WIDTH(WIDTH)) bus ();

  compare_search #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .found (found),
    .steps (steps),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // mode 0: honest comparator, 1: 3'b011 on the second probe, 2: always GT
  logic [WIDTH-1:0] target;
  int               mode;
  int               nprobe;
  logic             clr;
  logic [WIDTH-1:0] plog [8];

  always_comb begin
    bus.cmp_valid = bus.probe_valid;
    if (mode == 2)                     bus.cmp_res = CMP_GT;
    else if (mode == 1 && nprobe == 1) bus.cmp_res = 3'b011;
    else if (bus.probe > target)       bus.cmp_res = CMP_GT;
    else if (bus.probe < target)       bus.cmp_res = CMP_LT;
    else                               bus.cmp_res = CMP_EQ;
  end

  always @(posedge clk) begin
    if (clr) begin
      nprobe <= 0;
    end else if (bus.probe_valid && bus.cmp_valid) begin
      if (nprobe < 8) plog[nprobe[2:0]] <= bus.probe;
      nprobe <= nprobe + 1;
    end
  end

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_probe"}, 32'(bus.probe), 0);
    check({tag, "_pv"},    32'(bus.probe_valid), 0);
    check({tag, "_found"}, 32'(found), 0);
    check({tag, "_steps"}, 32'(steps), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
  endtask

  // seq holds the expected probes, first probe in the low nibble.
  task automatic run_search(input string tag, input logic [WIDTH-1:0] tgt, input int md,
                            input logic [31:0] seq, input int n,
                            input logic exp_done, input logic [WIDTH-1:0] exp_found);
    int k;
    target = tgt;
    mode   = md;
    @(negedge clk);
    clr   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    start = 1'b0;
    check({tag, "_first_probe"}, 32'(bus.probe), 7);
    check({tag, "_first_pv"},    32'(bus.probe_valid), 1);
    check({tag, "_first_steps"}, 32'(steps), 1);
    check({tag, "_first_busy"},  32'(busy), 1);
    k = 0;
    while (!(done || err) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_terminated"}, 32'(done || err), 1);
    check({tag, "_done"},   32'(done), 32'(exp_done));
    check({tag, "_err"},    32'(err), 32'(!exp_done));
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_pv"},     32'(bus.probe_valid), 0);
    check({tag, "_steps"},  32'(steps), 32'(n));
    check({tag, "_nprobe"}, 32'(nprobe), 32'(n));
    check({tag, "_found"},  32'(found), 32'(exp_found));
    for (int i = 0; i < n && i < 8; i++)
      check($sformatf("%s_probe%0d", tag, i), 32'(plog[i]), 32'(seq[4*i +: 4]));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    clr    = 1'b1;
    mode   = 0;
    target = '0;
    #2;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;

    run_search("t9",    4'd9,  0, 32'h0000_09B7, 3, 1'b1, 4'd9);
    run_search("t0",    4'd0,  0, 32'h0000_0137, 4, 1'b1, 4'd0);
    run_search("t15",   4'd15, 0, 32'h000F_EDB7, 5, 1'b1, 4'd15);
    run_search("bad2",  4'd5,  1, 32'h0000_0037, 2, 1'b0, 4'd15);
    run_search("t5",    4'd5,  0, 32'h0000_0537, 3, 1'b1, 4'd5);
    run_search("allgt", 4'd9,  2, 32'h0000_0137, 4, 1'b0, 4'd5);

    // Asynchronous reset in the middle of a search.
    target = 4'd15;
    mode   = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrst_pv_before", 32'(bus.probe_valid), 1);
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_search("after_rst", 4'd15, 0, 32'h000F_EDB7, 5, 1'b1, 4'd15);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
